snoop_response_unit: RTL and testbench
======================================

Name: snoop_response_unit

Overview:
Registered, queued successor to the combinational snoop-result decoder. It models NUM_PEERS peer caches answering snoops on the shared bus and merges their answers into one bus snoop result. Each accepted request is decoded once, buffered in a FIFO, and presented a fixed RESP_LATENCY later over a valid/ready handshake. It sits between the L2 bus-operation issue logic and the snoop-result consumer.

Parameters:
ADDR_WIDTH, 32, snoop address width (must be ≥4).
OP_WIDTH, 8, bus operation code width.
NUM_PEERS, 4, number of modelled peer caches (1..16).
FIFO_DEPTH, 4, number of pending responses (power of two, ≥2).
RESP_LATENCY, 2, minimum edges from accept to resp_valid (≥0).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
snoop_enable  input  1  0 forces all peer results to NOHIT; sampled at accept.
peer_mask  input  NUM_PEERS  1 = peer participates; sampled at accept.
req_valid  input  1  request valid.
req_ready  output  1  request accepted when req_valid && req_ready.
req_addr  input  ADDR_WIDTH  snooped address.
req_op  input  OP_WIDTH  bus operation code.
resp_valid  output  1  head response ready.
resp_ready  input  1  consumer accepts head.
resp_addr  output  ADDR_WIDTH  address of head response.
resp_result  output  2  merged snoop result.
resp_peer_result  output  2*NUM_PEERS  per-peer results; peer c in bits [2c+1:2c].
resp_illegal  output  1  head request had an unknown op.
pending_count  output  $clog2(FIFO_DEPTH+1)  occupied entries.

Behaviour:
- Result encoding: NOHIT=2'b00, HIT=2'b01, HITM=2'b10. 2'b11 is never produced.
- Peer decode: n_c = (req_addr[3:0] + c) mod 16, 4-bit wrap.
  - n_c in {2,8} → HIT.
  - n_c in {4,C} → HITM.
  - Otherwise NOHIT.
  - Masked peers, snoop_enable=0, and BUS_WRITE all give NOHIT.
- Op handling:
  - BUS_READ=1, BUS_RWIM=4 and BUS_INVALIDATE=3 are decoded.
  - BUS_WRITE=2 gives NOHIT.
  - Any other value gives NOHIT for all peers and resp_illegal=1.
- Merge: HITM if any peer is HITM, else HIT if any peer is HIT, else NOHIT.
- Decode happens at accept. The FIFO entry stores addr, merged result, per-peer results, illegal flag and age.
- req_ready = (pending_count != FIFO_DEPTH). No combinational path from resp_ready.
- Age timing:
  - A new entry is written with age 0.
  - Every entry's age increments on each later edge, saturating at RESP_LATENCY.
  - resp_valid = FIFO non-empty && head age == RESP_LATENCY.
  - An entry accepted at edge T is valid from edge T+RESP_LATENCY; with RESP_LATENCY=0, from edge T.
  - Back-to-back requests give one response per cycle after the initial latency.
- Pop: on resp_valid && resp_ready the head is removed at that edge.
- Simultaneous push and pop: count unchanged, both honoured. When full, the push is blocked by req_ready=0 even if a pop occurs that cycle.
- Outputs are valid while resp_valid=0 but carry don't-care data. Holding constraint: while resp_valid && !resp_ready, all resp_* outputs stay stable.
- Pointers wrap modulo FIFO_DEPTH.
- Reset (async assert, any time including mid-transfer):
  - Empties the FIFO and sets pending_count=0, resp_valid=0, req_ready=1.
  - resp_result=0, resp_peer_result=0, resp_addr=0, resp_illegal=0.
  - Entries in flight are discarded.

Decomposition:
- Package snoop_pkg:
  - snoop_result_t enum (NOHIT/HIT/HITM).
  - Bus op constants BUS_READ, BUS_WRITE, BUS_INVALIDATE, BUS_RWIM.
  - Nibble constants HIT_NIB_A=2, HIT_NIB_B=8, HITM_NIB_A=4, HITM_NIB_B=C.
  - merge function.
- One sub-module, snoop_peer_decode: combinational, one nibble+op+enable → snoop_result_t. Instantiate NUM_PEERS times via generate.

Test Plan:
- Reset, then addr 0x1002, op READ, mask 4'hF, RESP_LATENCY=2 → resp_valid from edge T+2; peer results {NOHIT,HITM,NOHIT,HIT} for peers 3..0; resp_result=HITM.
- Decode sweep of addresses 0x0, 0x5, 0x9, 0xE, 0xF (op READ):
  - 0x0 → HIT (peer2), 0x5 → HIT (peer3), 0x9 → HITM (peer3), 0xE → NOHIT, 0xF → HIT (peer3, wrap).
  - Repeat with op WRITE → all NOHIT; op 8'h7 → NOHIT, resp_illegal=1.
- Masking: addr 0x1002 with mask 4'b1011 → HIT; with snoop_enable=0 → NOHIT. Change mask after accept → result unchanged.
- Backpressure and full: hold resp_ready=0, push 5 requests. Expect:
  - 4 accepted, req_ready=0, pending_count=4.
  - Head outputs stable.
  - Release → 4 responses in order on consecutive cycles.
- Simultaneous push and pop at count 2 → count stays 2, order preserved. Streaming 8 requests with resp_ready=1 → 1 response per cycle after latency 2.
- Assert rst_n=0 mid-stream with 3 entries pending → resp_valid=0 and pending_count=0 immediately, without a clock edge. After release, a fresh request returns its own result only.

Source files
------------

// File: rtl/snoop_response_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : snoop_pkg
// Description : Shared types, bus-operation codes, address-nibble hit
//               patterns and the result-merge helper for the snoop
//               response unit.
// Revision    : 1.0 - initial release
// ============================================================================
package snoop_pkg;

  // Snoop result encoding; 2'b11 is never produced
  typedef enum logic [1:0] {
    NOHIT = 2'b00,
    HIT   = 2'b01,
    HITM  = 2'b10
  } snoop_result_t;

  // Bus operation codes
  localparam int BUS_READ       = 1;
  localparam int BUS_WRITE      = 2;
  localparam int BUS_INVALIDATE = 3;
  localparam int BUS_RWIM       = 4;

  // Address nibbles at which a modelled peer reports a hit
  localparam logic [3:0] HIT_NIB_A  = 4'h2;
  localparam logic [3:0] HIT_NIB_B  = 4'h8;
  localparam logic [3:0] HITM_NIB_A = 4'h4;
  localparam logic [3:0] HITM_NIB_B = 4'hC;

  // Priority merge of two peer answers: HITM beats HIT beats NOHIT
  function automatic snoop_result_t merge(input snoop_result_t a,
                                          input snoop_result_t b);
    if (a == HITM || b == HITM) begin
      return HITM;
    end else if (a == HIT || b == HIT) begin
      return HIT;
    end
    return NOHIT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_response_unit_peer_decode.sv
`default_nettype none
// ============================================================================
// Module      : snoop_peer_decode
// Description : Combinational answer of one modelled peer cache for a
//               single snoop: address nibble + bus op + enable -> result.
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_peer_decode
  import snoop_pkg::*;
#(
  parameter int OP_WIDTH = 8
) (
  input  logic [3:0]          nibble_i,
  input  logic [OP_WIDTH-1:0] op_i,
  input  logic                enable_i,
  output snoop_result_t       result_o
);

  logic op_snooped;

  // Only reads, invalidates and read-with-intent-to-modify probe the peer;
  // writes and unknown codes always answer NOHIT.
  always_comb begin
    result_o   = NOHIT;
    op_snooped = (op_i == OP_WIDTH'(BUS_READ))       ||
                 (op_i == OP_WIDTH'(BUS_INVALIDATE)) ||
                 (op_i == OP_WIDTH'(BUS_RWIM));
    if (enable_i && op_snooped) begin
      if (nibble_i == HIT_NIB_A || nibble_i == HIT_NIB_B) begin
        result_o = HIT;
      end else if (nibble_i == HITM_NIB_A || nibble_i == HITM_NIB_B) begin
        result_o = HITM;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snoop_response_unit.sv
`default_nettype none
// ============================================================================
// Module      : snoop_response_unit
// Description : Decodes each accepted snoop request across NUM_PEERS
//               modelled peers, queues the merged answer in a FIFO and
//               presents it RESP_LATENCY edges later on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_response_unit
  import snoop_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int OP_WIDTH     = 8,
  parameter int NUM_PEERS    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int RESP_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             snoop_enable,
  input  logic [NUM_PEERS-1:0]             peer_mask,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [OP_WIDTH-1:0]              req_op,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [ADDR_WIDTH-1:0]            resp_addr,
  output logic [1:0]                       resp_result,
  output logic [2*NUM_PEERS-1:0]           resp_peer_result,
  output logic                             resp_illegal,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AGE_W = (RESP_LATENCY > 0) ? $clog2(RESP_LATENCY + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(RESP_LATENCY);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------- decode
  snoop_result_t                peer_res [NUM_PEERS];
  snoop_result_t                merged;
  logic [2*NUM_PEERS-1:0]       peer_vec;
  logic                         illegal;

  for (genvar c = 0; c < NUM_PEERS; c++) begin : g_peer
    logic [3:0] nib;
    // Each peer sees the address nibble rotated by its index (4-bit wrap)
    assign nib = req_addr[3:0] + 4'(c);

    snoop_peer_decode #(
      .OP_WIDTH (OP_WIDTH)
    ) u_dec (
      .nibble_i (nib),
      .op_i     (req_op),
      .enable_i (snoop_enable && peer_mask[c]),
      .result_o (peer_res[c])
    );
  end

  // Pack per-peer answers and fold them into one bus result
  always_comb begin
    merged   = NOHIT;
    peer_vec = '0;
    for (int c = 0; c < NUM_PEERS; c++) begin
      peer_vec[2*c +: 2] = peer_res[c];
      merged             = merge(merged, peer_res[c]);
    end
  end

  assign illegal = !((req_op == OP_WIDTH'(BUS_READ))       ||
                     (req_op == OP_WIDTH'(BUS_WRITE))      ||
                     (req_op == OP_WIDTH'(BUS_INVALIDATE)) ||
                     (req_op == OP_WIDTH'(BUS_RWIM)));

  // ------------------------------------------------------------------ FIFO
  logic [ADDR_WIDTH-1:0]  addr_q [FIFO_DEPTH];
  logic [1:0]             res_q  [FIFO_DEPTH];
  logic [2*NUM_PEERS-1:0] peer_q [FIFO_DEPTH];
  logic                   ill_q  [FIFO_DEPTH];
  logic [AGE_W-1:0]       age_q  [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push, pop;

  assign req_ready  = (count_q != CNT_FULL);
  assign push       = req_valid && req_ready;
  assign resp_valid = (count_q != '0) && (age_q[rd_ptr_q] == AGE_MAX);
  assign pop        = resp_valid && resp_ready;

  // Next-state for pointers and occupancy; pointers wrap at power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry ages: cleared on write, otherwise count up to the latency and hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push && (wr_ptr_q == PTR_W'(i))) begin
          age_q[i] <= '0;
        end else if (age_q[i] < AGE_MAX) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  // Payload storage; needs no reset because outputs are gated by resp_valid
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= req_addr;
      res_q[wr_ptr_q]  <= merged;
      peer_q[wr_ptr_q] <= peer_vec;
      ill_q[wr_ptr_q]  <= illegal;
    end
  end

  // Head outputs read as zero whenever no response is presented
  assign resp_addr        = resp_valid ? addr_q[rd_ptr_q] : '0;
  assign resp_result      = resp_valid ? res_q[rd_ptr_q]  : 2'b00;
  assign resp_peer_result = resp_valid ? peer_q[rd_ptr_q] : '0;
  assign resp_illegal     = resp_valid ? ill_q[rd_ptr_q]  : 1'b0;
  assign pending_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_snoop_response_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_response_unit
// Description : Scoreboard bench for snoop_response_unit with directed,
//               hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_response_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        snoop_enable = 1'b0;
  logic [3:0]  peer_mask = 4'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_op = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_addr;
  logic [1:0]  resp_result;
  logic [7:0]  resp_peer_result;
  logic        resp_illegal;
  logic [2:0]  pending_count;

  snoop_response_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .snoop_enable     (snoop_enable),
    .peer_mask        (peer_mask),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_op           (req_op),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_addr        (resp_addr),
    .resp_result      (resp_result),
    .resp_peer_result (resp_peer_result),
    .resp_illegal     (resp_illegal),
    .pending_count    (pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  res;
    logic [7:0]  peer;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every handshaken response against the queue
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      pop_cyc.push_back(cyc);
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got addr=%h res=%0d, expected no response",
                 resp_addr, resp_result);
      end else begin
        mon_e = sb.pop_front();
        if ({resp_addr, resp_result, resp_peer_result, resp_illegal} !==
            {mon_e.addr, mon_e.res, mon_e.peer, mon_e.ill}) begin
          fails++;
          $display("FAIL resp_data: got addr=%h res=%0d peer=%h ill=%0b, expected addr=%h res=%0d peer=%h ill=%0b",
                   resp_addr, resp_result, resp_peer_result, resp_illegal,
                   mon_e.addr, mon_e.res, mon_e.peer, mon_e.ill);
        end
      end
    end
  end

  // Present one request for one cycle; expectation queued only if accepted
  task automatic issue(input logic [31:0] a, input logic [7:0] op,
                       input logic [3:0] mask, input logic en,
                       input logic [1:0] er, input logic [7:0] ep,
                       input logic eil, output logic acc);
    exp_t e;
    req_valid    = 1'b1;
    req_addr     = a;
    req_op       = op;
    peer_mask    = mask;
    snoop_enable = en;
    @(negedge clk);
    acc = req_ready;
    if (acc) begin
      e.addr = a; e.res = er; e.peer = ep; e.ill = eil;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid    = 1'b0;
    peer_mask    = 4'h0;
    snoop_enable = 1'b0;
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("drain_empty", sb.size(), 0);
  endtask

  // Hand-computed decode tables (READ op, mask F, enable 1)
  logic [3:0]  sw_nib  [5] = '{4'h0, 4'h5, 4'h9, 4'hE, 4'hF};
  logic [1:0]  sw_res  [5] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
  logic [7:0]  sw_peer [5] = '{8'h10, 8'h40, 8'h80, 8'h00, 8'h40};
  logic [1:0]  nb_res  [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
  logic [7:0]  nb_peer [8] = '{8'h10, 8'h84, 8'h21, 8'h08, 8'h02, 8'h40, 8'h10, 8'h04};

  initial begin
    logic acc;
    int   t0;
    logic [7:0] sw_op [3];
    sw_op[0] = 8'd1; sw_op[1] = 8'd2; sw_op[2] = 8'h07;

    // Reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_pending", pending_count, 0);
    chk("rst_resp_addr", resp_addr, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_peer", resp_peer_result, 0);
    chk("rst_resp_illegal", resp_illegal, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency of a single request
    issue(32'h0000_1002, 8'd1, 4'hF, 1'b1, 2'd2, 8'h21, 1'b0, acc);
    idle();
    @(negedge clk); chk("lat_T0", resp_valid, 0);
    @(negedge clk); chk("lat_T1", resp_valid, 0);
    @(negedge clk); chk("lat_T2", resp_valid, 1);
    chk("lat_result", resp_result, 2);
    chk("lat_peer", resp_peer_result, 8'h21);
    @(posedge clk); #1;
    drain();

    // Decode sweep: READ, WRITE, unknown op
    resp_ready = 1'b1;
    for (int o = 0; o < 3; o++) begin
      for (int k = 0; k < 5; k++) begin
        issue({28'h1234_560, sw_nib[k]}, sw_op[o], 4'hF, 1'b1,
              (o == 0) ? sw_res[k] : 2'd0,
              (o == 0) ? sw_peer[k] : 8'h00,
              (o == 2), acc);
        chk("sweep_accept", acc, 1);
      end
    end
    idle();
    drain();

    // Masking, disable, and mask change after accept
    issue(32'h0000_1002, 8'd1, 4'b1011, 1'b1, 2'd1, 8'h01, 1'b0, acc);
    issue(32'h0000_1002, 8'd1, 4'hF, 1'b0, 2'd0, 8'h00, 1'b0, acc);
    issue(32'h0000_1002, 8'd3, 4'hF, 1'b1, 2'd2, 8'h21, 1'b0, acc);
    idle();
    drain();

    // Backpressure and full
    for (int i = 0; i < 5; i++) begin
      issue(32'hA000_0000 + i, 8'd4, 4'hF, 1'b1, nb_res[i], nb_peer[i], 1'b0, acc);
      chk("full_accept", acc, (i < 4) ? 1 : 0);
    end
    idle();
    chk("full_pending", pending_count, 4);
    chk("full_req_ready", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_addr", resp_addr, 32'hA000_0000);
      chk("hold_result", resp_result, 1);
    end
    @(posedge clk); #1;
    pop_cyc.delete();
    drain();
    chk("bp_pop_count", pop_cyc.size(), 4);
    chk("bp_consecutive", (pop_cyc.size() == 4) ? pop_cyc[3] - pop_cyc[0] : -1, 3);

    // Simultaneous push and pop at count 2
    issue(32'hB000_0000, 8'd1, 4'hF, 1'b1, 2'd1, 8'h10, 1'b0, acc);
    issue(32'hB000_0005, 8'd1, 4'hF, 1'b1, 2'd1, 8'h40, 1'b0, acc);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("pp_pending_before", pending_count, 2);
    resp_ready = 1'b1;
    issue(32'hB000_0009, 8'd1, 4'hF, 1'b1, 2'd2, 8'h80, 1'b0, acc);
    resp_ready = 1'b0;
    idle();
    chk("pp_accept", acc, 1);
    chk("pp_pending_after", pending_count, 2);
    drain();

    // Streaming 8 back-to-back requests
    resp_ready = 1'b1;
    pop_cyc.delete();
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      issue(32'hC000_0000 + i, 8'd1, 4'hF, 1'b1, nb_res[i], nb_peer[i], 1'b0, acc);
      if (i == 0) t0 = cyc;
      chk("stream_accept", acc, 1);
    end
    idle();
    drain();
    chk("stream_pops", pop_cyc.size(), 8);
    chk("stream_latency", (pop_cyc.size() == 8) ? pop_cyc[0] - t0 : -1, 2);
    chk("stream_rate", (pop_cyc.size() == 8) ? pop_cyc[7] - pop_cyc[0] : -1, 7);

    // Asynchronous reset mid-stream
    issue(32'hD000_0000, 8'd1, 4'hF, 1'b1, 2'd1, 8'h10, 1'b0, acc);
    issue(32'hD000_0005, 8'd1, 4'hF, 1'b1, 2'd1, 8'h40, 1'b0, acc);
    issue(32'hD000_0009, 8'd1, 4'hF, 1'b1, 2'd2, 8'h80, 1'b0, acc);
    idle();
    chk("mid_pending", pending_count, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_pending", pending_count, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_addr", resp_addr, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h1234_567F, 8'd1, 4'hF, 1'b1, 2'd1, 8'h40, 1'b0, acc);
    idle();
    drain();
    resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("final_pending", pending_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
